// File: rtl/gamma_lut_ctrl_pkg.sv
// Shared types and helpers for the gamma LUT controller: default widths,
// FSM state encoding and the identity-curve scaling used during init fill.
package gamma_lut_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    PEND
  } lutStateT;

  // Stretch a 10-bit index to 12 bits by repeating its top bits, so 0 maps
  // to 0x000 and 1023 maps to 0xFFF.
  function automatic logic [DATA_W_DEF-1:0] identityScale(input logic [ADDR_W_DEF-1:0] idx);
    return {idx, idx[ADDR_W_DEF-1 -: (DATA_W_DEF - ADDR_W_DEF)]};
  endfunction

endpackage

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma LUT controller: identity fill of both banks after
// reset, host writes to the shadow bank, and frame-aligned bank swaps.
module gamma_lut_ctrl
  import gamma_lut_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_ready,
  input  logic              commit_req,
  input  logic              frame_start,
  output logic              commit_ack,
  output logic              lut_we,
  output logic              lut_bank,
  output logic [ADDR_W-1:0] lut_addr,
  output logic [DATA_W-1:0] lut_wdata,
  output logic              active_bank,
  output logic              init_done
);

  lutStateT          state, nextState;
  logic [ADDR_W:0]   fillCnt, nextFillCnt;
  logic              activeBankNext;
  logic              lutWeNext;
  logic              lutBankNext;
  logic [ADDR_W-1:0] lutAddrNext;
  logic [DATA_W-1:0] lutWdataNext;
  logic              commitAckNext;
  logic              initDoneNext;

  // All controller state and LUT write-port outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= INIT;
      fillCnt     <= '0;
      active_bank <= 1'b0;
      lut_we      <= 1'b0;
      lut_bank    <= 1'b0;
      lut_addr    <= '0;
      lut_wdata   <= '0;
      commit_ack  <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= nextState;
      fillCnt     <= nextFillCnt;
      active_bank <= activeBankNext;
      lut_we      <= lutWeNext;
      lut_bank    <= lutBankNext;
      lut_addr    <= lutAddrNext;
      lut_wdata   <= lutWdataNext;
      commit_ack  <= commitAckNext;
      init_done   <= initDoneNext;
    end
  end

  // The fill counter's top bit selects the bank, so one pass covers both
  // banks. The bank only flips from PEND on frame_start, never mid-frame.
  always_comb begin
    nextState      = state;
    nextFillCnt    = fillCnt;
    activeBankNext = active_bank;
    lutWeNext      = 1'b0;
    lutBankNext    = lut_bank;
    lutAddrNext    = lut_addr;
    lutWdataNext   = lut_wdata;
    commitAckNext  = 1'b0;
    initDoneNext   = init_done;
    cfg_ready      = 1'b0;

    case (state)
      INIT: begin
        lutWeNext    = 1'b1;
        lutBankNext  = fillCnt[ADDR_W];
        lutAddrNext  = fillCnt[ADDR_W-1:0];
        lutWdataNext = DATA_W'(identityScale(ADDR_W_DEF'(fillCnt[ADDR_W-1:0])));
        if (&fillCnt) begin
          nextState    = IDLE;
          initDoneNext = 1'b1;
        end else begin
          nextFillCnt = fillCnt + 1'b1;
        end
      end
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_wr) begin
          lutWeNext    = 1'b1;
          lutBankNext  = ~active_bank;
          lutAddrNext  = cfg_addr;
          lutWdataNext = cfg_wdata;
        end
        if (commit_req) begin
          nextState = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          activeBankNext = ~active_bank;
          commitAckNext  = 1'b1;
          nextState      = IDLE;
        end
      end
      default: nextState = INIT;
    endcase
  end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Randomized bench for gamma_lut_ctrl: a behavioural model of the controller
// is checked against the DUT every cycle, plus directed literal expectations.
module tb_gamma_lut_ctrl;

  localparam int AW = 10;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          commit_req = 1'b0;
  logic          frame_start = 1'b0;
  logic          cfg_ready;
  logic          commit_ack;
  logic          lut_we;
  logic          lut_bank;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_wdata;
  logic          active_bank;
  logic          init_done;

  int checkCount = 0;
  int passCount = 0;

  gamma_lut_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .commit_req(commit_req), .frame_start(frame_start), .commit_ack(commit_ack),
    .lut_we(lut_we), .lut_bank(lut_bank), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .active_bank(active_bank), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = filling, 1 = accepting host traffic,
  // 2 = waiting for a frame boundary to swap.
  int mPhase = 0;
  int mFill = 0;
  bit mAct = 0, mWe = 0, mBank = 0, mAck = 0, mDone = 0;
  int mAddr = 0, mData = 0;
  int modelRam[2][1024];
  int dutRam[2][1024];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mPhase = 0; mFill = 0; mAct = 0; mWe = 0; mBank = 0;
      mAck = 0; mDone = 0; mAddr = 0; mData = 0;
    end else begin
      mWe = 0;
      mAck = 0;
      if (mPhase == 0) begin
        mWe = 1;
        mBank = (mFill >= 1024);
        mAddr = mFill % 1024;
        mData = mAddr * 4 + mAddr / 256;
        modelRam[mBank][mAddr] = mData;
        if (mFill == 2047) begin
          mPhase = 1;
          mDone = 1;
        end else begin
          mFill++;
        end
      end else if (mPhase == 1) begin
        if (cfg_wr) begin
          mWe = 1;
          mBank = !mAct;
          mAddr = int'(cfg_addr);
          mData = int'(cfg_wdata);
          modelRam[mBank][mAddr] = mData;
        end
        if (commit_req) mPhase = 2;
      end else if (frame_start) begin
        mAct = !mAct;
        mAck = 1;
        mPhase = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    checkOutput("lut_we", 32'(lut_we), 32'(mWe));
    checkOutput("lut_bank", 32'(lut_bank), 32'(mBank));
    checkOutput("lut_addr", 32'(lut_addr), 32'(mAddr));
    checkOutput("lut_wdata", 32'(lut_wdata), 32'(mData));
    checkOutput("active_bank", 32'(active_bank), 32'(mAct));
    checkOutput("commit_ack", 32'(commit_ack), 32'(mAck));
    checkOutput("init_done", 32'(init_done), 32'(mDone));
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(mPhase == 1));
    if (lut_we === 1'b1) dutRam[lut_bank][lut_addr] = int'(lut_wdata);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input bit cr, input bit fs);
    cfg_wr = wr;
    cfg_addr = addr;
    cfg_wdata = data;
    commit_req = cr;
    frame_start = fs;
    tick();
  endtask

  task automatic randStim(input bit allowFs);
    applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 4095)),
                  $urandom_range(0, 9) == 0, allowFs && ($urandom_range(0, 14) == 0));
  endtask

  // Drive junk traffic through the fill and confirm 2048 back-to-back writes.
  task automatic fillInit();
    int weCycles = 0;
    int cycles = 0;
    bit seen = 0;
    while (!seen && cycles < 2200) begin
      randStim(1'b1);
      cycles++;
      if (lut_we === 1'b1) weCycles++;
      if (cycles == 1) checkOutput("initFirstAddr", 32'(lut_addr), 32'h0);
      if (init_done === 1'b1) seen = 1;
    end
    applyStimulus(0, '0, '0, 0, 0);
    checkOutput("initSeen", 32'(seen), 32'h1);
    checkOutput("initWeCycles", 32'(weCycles), 32'd2048);
    checkOutput("initCycles", 32'(cycles), 32'd2048);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mism;
    int readyCnt;
    rstn = 1'b0;
    repeat (3) tick();
    checkOutput("rstInitDone", 32'(init_done), 32'h0);
    checkOutput("rstLutWe", 32'(lut_we), 32'h0);
    checkOutput("rstActive", 32'(active_bank), 32'h0);

    rstn = 1'b1;
    fillInit();
    checkOutput("ramB1E1023", 32'(dutRam[1][1023]), 32'hFFF);
    checkOutput("ramB0E512", 32'(dutRam[0][512]), 32'h802);
    checkOutput("ramB1E512", 32'(dutRam[1][512]), 32'h802);
    checkOutput("ramB0E0", 32'(dutRam[0][0]), 32'h000);
    checkOutput("postInitReady", 32'(cfg_ready), 32'h1);
    checkOutput("postInitActive", 32'(active_bank), 32'h0);

    applyStimulus(1, 10'h010, 12'hABC, 0, 0);
    checkOutput("wrWe", 32'(lut_we), 32'h1);
    checkOutput("wrBank", 32'(lut_bank), 32'h1);
    checkOutput("wrAddr", 32'(lut_addr), 32'h010);
    checkOutput("wrData", 32'(lut_wdata), 32'hABC);
    applyStimulus(0, '0, '0, 0, 0);

    // Commit then hold off the frame boundary for 100 cycles.
    applyStimulus(0, '0, '0, 1, 0);
    readyCnt = 0;
    for (int i = 0; i < 99; i++) begin
      randStim(1'b0);
      if (cfg_ready === 1'b1) readyCnt++;
    end
    checkOutput("pendReadyCycles", 32'(readyCnt), 32'h0);
    applyStimulus(0, '0, '0, 0, 1);
    checkOutput("swapActive", 32'(active_bank), 32'h1);
    checkOutput("swapAck", 32'(commit_ack), 32'h1);
    applyStimulus(1, 10'h020, 12'h123, 0, 0);
    checkOutput("ackPulseEnd", 32'(commit_ack), 32'h0);
    checkOutput("postSwapBank", 32'(lut_bank), 32'h0);

    applyStimulus(0, '0, '0, 1, 1);
    checkOutput("coincidentNoSwap", 32'(active_bank), 32'h1);
    checkOutput("coincidentNoAck", 32'(commit_ack), 32'h0);
    repeat (5) applyStimulus(0, '0, '0, 0, 0);
    applyStimulus(0, '0, '0, 0, 1);
    checkOutput("laterSwapActive", 32'(active_bank), 32'h0);
    checkOutput("laterSwapAck", 32'(commit_ack), 32'h1);

    repeat (1500) randStim(1'b1);

    // Reset while a commit is pending.
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("prePendReady", 32'(cfg_ready), 32'h0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("asyncInitDone", 32'(init_done), 32'h0);
    checkOutput("asyncReady", 32'(cfg_ready), 32'h0);
    checkOutput("asyncWe", 32'(lut_we), 32'h0);
    checkOutput("asyncActive", 32'(active_bank), 32'h0);
    checkOutput("asyncAddr", 32'(lut_addr), 32'h0);
    checkOutput("asyncData", 32'(lut_wdata), 32'h0);
    tick();
    applyStimulus(0, '0, '0, 0, 1);
    rstn = 1'b1;
    fillInit();
    checkOutput("noSwapAfterReset", 32'(active_bank), 32'h0);

    repeat (300) randStim(1'b1);

    mism = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 1024; a++)
        if (dutRam[b][a] != modelRam[b][a]) mism++;
    checkOutput("ramContents", 32'(mism), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
